// File: rtl/alu_shift_pkg.sv
// Shared types for the multi-cycle shifter: op encodings and FSM states.
package alu_shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        SHIFT_SLL = OP_SLL,
        SHIFT_SRL = OP_SRL,
        SHIFT_SRA = OP_SRA,
        SHIFT_ROR = OP_ROR
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } shift_state_e;

endpackage

// File: rtl/alu_shift_seq_if.sv
// Request/response handshake bundle of the shifter; master is the execute stage.
interface alu_shift_seq_if #(
    parameter int DATA_W = 32
) ();
    localparam int SHAMT_W = $clog2(DATA_W);

    logic               i_valid;
    logic               o_ready;
    logic [DATA_W-1:0]  i_data;
    logic [SHAMT_W-1:0] i_shamt;
    logic [1:0]         i_op;
    logic               o_valid;
    logic               i_ready;
    logic [DATA_W-1:0]  o_result;
    logic               o_busy;

    modport master (
        output i_valid, i_data, i_shamt, i_op, i_ready,
        input  o_ready, o_valid, o_result, o_busy
    );

    modport slave (
        input  i_valid, i_data, i_shamt, i_op, i_ready,
        output o_ready, o_valid, o_result, o_busy
    );
endinterface

// File: rtl/alu_shift_step.sv
// Combinational single-step shifter: moves one word by 0..STEP positions.
// Rotate support is compiled in only when ALU_SHIFT_ROTATE_EN is defined.
module alu_shift_step
    import alu_shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 1,
    localparam int SHAMT_W = $clog2(DATA_W),
    localparam int N_W     = $clog2(STEP + 1)
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [N_W-1:0]    i_n,
    input  shift_op_e         i_op,
    input  logic              i_fill,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] fill_mask;
`ifdef ALU_SHIFT_ROTATE_EN
    logic [SHAMT_W:0]  rot_n;
    assign rot_n = (SHAMT_W + 1)'(DATA_W) - (SHAMT_W + 1)'(i_n);
`endif

    // Ones in the top i_n positions: the bits vacated by a right shift.
    assign fill_mask = ~({DATA_W{1'b1}} >> i_n);

    always_comb begin
        // NOTE: default first so every path assigns o_data and no latch is inferred.
        o_data = i_data >> i_n;
        case (i_op)
            SHIFT_SLL: o_data = i_data << i_n;
            SHIFT_SRA: o_data = (i_data >> i_n) | (fill_mask & {DATA_W{i_fill}});
`ifdef ALU_SHIFT_ROTATE_EN
            SHIFT_ROR: o_data = (i_data >> i_n) | (i_data << rot_n);
`endif
            default:   o_data = i_data >> i_n;
        endcase
    end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle SLL/SRL/SRA(/ROR) shifter, at most STEP positions per clock.
// Define ALU_SHIFT_ROTATE_EN to make op 2'b11 a rotate-right instead of SRL.
module alu_shift_seq
    import alu_shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 1,
    localparam int SHAMT_W = $clog2(DATA_W)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    alu_shift_seq_if.slave   bus
);

    localparam int N_W      = $clog2(STEP + 1);
    // rem never exceeds DATA_W-1, so capping the step there keeps it in SHAMT_W bits.
    localparam int STEP_CAP = (STEP >= DATA_W) ? DATA_W - 1 : STEP;
    localparam logic [SHAMT_W-1:0] STEP_N = SHAMT_W'(STEP_CAP);

    shift_state_e       state_q, state_d;
    shift_op_e          op_q, op_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0]  work_q, work_d;
    logic [SHAMT_W-1:0] n_amt;
    logic [DATA_W-1:0]  step_out;

    assign n_amt = (rem_q < STEP_N) ? rem_q : STEP_N;

    // SRA keeps the MSB fixed, so the working register's MSB is the latched sign.
    alu_shift_step #(
        .DATA_W (DATA_W),
        .STEP   (STEP)
    ) u_step (
        .i_data (work_q),
        .i_n    (N_W'(n_amt)),
        .i_op   (op_q),
        .i_fill (work_q[DATA_W-1]),
        .o_data (step_out)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        work_d  = work_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    work_d  = bus.i_data;
                    rem_d   = bus.i_shamt;
                    op_d    = shift_op_e'(bus.i_op);
                    state_d = (bus.i_shamt == '0) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                work_d = step_out;
                rem_d  = rem_q - n_amt;
                if (rem_d == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.i_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: the working register is reset too, so o_result reads 0 out of reset.
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= SHIFT_SLL;
            rem_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
        end
    end

    assign bus.o_ready  = (state_q == ST_IDLE) && i_rst_n;
    assign bus.o_valid  = (state_q == ST_DONE);
    assign bus.o_busy   = (state_q == ST_BUSY) || (state_q == ST_DONE);
    assign bus.o_result = work_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Bench for alu_shift_seq: four instances (STEP 1, 2, 8, 32) share one stimulus
// stream and are checked against an arithmetic shift model and latency rule.
module tb_alu_shift_seq;

    localparam int DW   = 32;
    localparam int NDUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tb_valid, tb_ready;
    logic [31:0] tb_data;
    logic [4:0]  tb_shamt;
    logic [1:0]  tb_op;

    logic [NDUT-1:0] v_vec, r_vec, b_vec;
    logic [31:0]     res_a [NDUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic int step_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 8;
            default: return 32;
        endcase
    endfunction

    generate
        for (genvar k = 0; k < NDUT; k++) begin : g_dut
            localparam int S = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 8 : 32;
            alu_shift_seq_if #(.DATA_W(DW)) bus ();
            assign bus.i_valid = tb_valid;
            assign bus.i_data  = tb_data;
            assign bus.i_shamt = tb_shamt;
            assign bus.i_op    = tb_op;
            assign bus.i_ready = tb_ready;
            assign v_vec[k]    = bus.o_valid;
            assign r_vec[k]    = bus.o_ready;
            assign b_vec[k]    = bus.o_busy;
            assign res_a[k]    = bus.o_result;
            alu_shift_seq #(.DATA_W(DW), .STEP(S)) u_dut (
                .i_clk   (clk),
                .i_rst_n (rst_n),
                .bus     (bus.slave)
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: the whole shift done at once with plain operators.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] op);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $unsigned($signed(d) >>> s);
`ifdef ALU_SHIFT_ROTATE_EN
            default: return (d >> s) | (d << (32 - s));
`else
            default: return d >> s;
`endif
        endcase
    endfunction

    // One request to all instances; hold>0 keeps i_ready low until hold cycles
    // after the slowest instance should have finished.
    task automatic run_txn(input logic [31:0] d, input int s, input logic [1:0] op, input int hold);
        int lat [NDUT];
        int end_m [NDUT];
        int max_lat = 0;
        int rel, last;
        logic [31:0] exp;
        bit ev;
        exp = ref_shift(d, s, op);
        for (int k = 0; k < NDUT; k++) begin
            lat[k] = (s + step_of(k) - 1) / step_of(k);
            if (lat[k] > max_lat) max_lat = lat[k];
        end
        rel = max_lat + hold;
        for (int k = 0; k < NDUT; k++) end_m[k] = (hold == 0) ? lat[k] : rel;
        last = ((hold == 0) ? max_lat : rel) + 1;

        check("ready_before_accept", 32'(r_vec), 32'hF);
        tb_valid = 1'b1;
        tb_data  = d;
        tb_shamt = 5'(s);
        tb_op    = op;
        tb_ready = (hold == 0);
        @(posedge clk); #1;
        tb_valid = 1'b0;
        tb_data  = $urandom;
        tb_shamt = 5'($urandom_range(0, 31));
        tb_op    = 2'($urandom_range(0, 3));
        for (int m = 0; m <= last; m++) begin
            for (int k = 0; k < NDUT; k++) begin
                ev = (m >= lat[k]) && (m <= end_m[k]);
                check($sformatf("valid step%0d op%0d s%0d m%0d", step_of(k), op, s, m), 32'(v_vec[k]), 32'(ev));
                check($sformatf("busy step%0d s%0d m%0d", step_of(k), s, m), 32'(b_vec[k]), 32'(m <= end_m[k]));
                if (ev) check($sformatf("result step%0d op%0d d%h s%0d m%0d", step_of(k), op, d, s, m), res_a[k], exp);
            end
            if (hold != 0 && m == rel) tb_ready = 1'b1;
            if (m < last) begin
                @(posedge clk); #1;
            end
        end
        tb_ready = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        tb_valid = 1'b0;
        tb_ready = 1'b1;
        tb_data  = '0;
        tb_shamt = '0;
        tb_op    = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(r_vec), 32'h0);
        check("rst_valid", 32'(v_vec), 32'h0);
        check("rst_busy",  32'(b_vec), 32'h0);
        for (int k = 0; k < NDUT; k++) check($sformatf("rst_result%0d", k), res_a[k], 32'h0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(r_vec), 32'hF);

        // Directed cases from the shifter's worked examples.
        run_txn(32'h8000_0000, 31, 2'b01, 0);
        run_txn(32'hF000_0000, 4,  2'b10, 0);
        run_txn(32'h0000_0001, 0,  2'b00, 0);
        run_txn(32'h1234_5678, 7,  2'b00, 5);
        run_txn(32'h0000_0001, 1,  2'b11, 0);
        run_txn(32'h8765_4321, 31, 2'b10, 2);

        // Reset in the middle of a long request drops it.
        tb_ready = 1'b0;
        tb_valid = 1'b1;
        tb_data  = 32'h8000_0000;
        tb_shamt = 5'd31;
        tb_op    = 2'b01;
        @(posedge clk); #1;
        tb_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midbusy_busy", 32'(b_vec), 32'hF);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid", 32'(v_vec), 32'h0);
        check("midrst_busy",  32'(b_vec), 32'h0);
        check("midrst_ready", 32'(r_vec), 32'h0);
        for (int k = 0; k < NDUT; k++) check($sformatf("midrst_result%0d", k), res_a[k], 32'h0);
        rst_n = 1'b1;
        #1;
        check("midrst_ready_release", 32'(r_vec), 32'hF);
        tb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("dropped_valid%0d", i), 32'(v_vec), 32'h0);
        end
        run_txn(32'hDEAD_BEEF, 13, 2'b10, 0);

        // Randomized traffic with occasional backpressure.
        for (int t = 0; t < 40; t++) begin
            run_txn($urandom, $urandom_range(0, 31), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_shift_seq.md
# alu_shift_seq

Parametrised, multi-cycle shifter that supersedes the single-shot logical-right shifter in the ALU datapath. It supports SLL/SRL/SRA (and optionally ROR) at configurable data width, shifting at most `STEP` bit positions per clock. Input and output use a valid/ready handshake so the execute stage can stall on it. It sits beside the ALU as a shared shift resource.

## Interface
- `DATA_W`, 32: operand width; power of two, at least 8.
- `STEP`, 1: maximum bit positions shifted per cycle; power of two, 1 ≤ STEP ≤ DATA_W.
- `SHAMT_W`, $clog2(DATA_W): shift-amount width (derived, not overridden).
- `i_clk` in 1: single clock, rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_valid` in 1: request valid.
- `o_ready` out 1: block can accept a request.
- `i_data` in DATA_W: operand.
- `i_shamt` in SHAMT_W: shift amount, 0..DATA_W-1.
- `i_op` in 2: 00 SLL, 01 SRL, 10 SRA, 11 ROR/reserved.
- `o_valid` out 1: result valid.
- `i_ready` in 1: consumer accepts the result.
- `o_result` out DATA_W: shifted value.
- `o_busy` out 1: high in BUSY or DONE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- `o_ready` = (state == IDLE) && i_rst_n.
- `o_valid` = (state == DONE).
- Accept means `i_valid && o_ready` at a rising edge:
  - Latch `i_data` into the working register, `i_shamt` into the remaining counter `rem`, and `i_op`.
  - Next state is DONE if `i_shamt == 0`, otherwise BUSY.
- BUSY, each edge:
  - Shift the working register by `n = min(STEP, rem)` positions, then `rem -= n`.
  - Move to DONE when the new `rem` is 0.
- Fill rules:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: replicate bit DATA_W-1 of the latched operand.
  - ROR: bits leaving the LSB re-enter at the MSB.
- DONE:
  - `o_result` holds the working register, stable while `o_valid && !i_ready`.
  - On `i_ready`, go to IDLE.
  - No accept in the same cycle, because `o_ready` is 0 in DONE.
- Inputs are ignored outside an accept edge. Changing `i_data`, `i_op` or `i_shamt` during BUSY has no effect.
- `i_op == 11` without the macro behaves exactly as SRL.
- Reset, at any state: next state IDLE, `rem` = 0, working register = 0. A request in flight is dropped and produces no `o_valid`.

## Timing
- Reset values: `o_valid` 0, `o_busy` 0, `o_result` 0. `o_ready` is 0 while `i_rst_n` is low, then 1 in the first cycle after reset deasserts.
- Accept at edge E0: `o_valid` first high after edge E0 + ceil(i_shamt/STEP).
  - `shamt` 0: high after E0.
  - DATA_W = 32, STEP = 1, `shamt` 31: high after E0 + 31.
  - STEP = 8, `shamt` 31: high after E0 + 4.
- Throughput: one request per ceil(shamt/STEP) + 2 cycles, when `i_ready` is held high.
- `o_result` is driven from a register; there is no combinational path from `i_data` to `o_result`.
- `o_ready` depends on state only; there is no combinational path from `i_valid` or `i_ready`.

## Configuration
- Macro `ALU_SHIFT_ROTATE_EN`.
- Defined: `i_op == 11` performs rotate-right by `i_shamt`, with the same cycle count as the other ops.
- Undefined: no rotate hardware; `i_op == 11` is an alias of SRL.

## Structure
- Package `alu_shift_pkg` holds:
  - enum `shift_op_e` (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR);
  - enum `shift_state_e` (ST_IDLE, ST_BUSY, ST_DONE);
  - op-encoding localparams.
- Sub-module `alu_shift_step`: a combinational shifter of one DATA_W word by 0..STEP positions, given the op and fill bit. The top level contains the FSM, counter and registers.

## Test plan
- DATA_W 32, STEP 1, SRL `0x8000_0000` by 31 → `o_result` `0x0000_0001`, `o_valid` after exactly 31 edges.
- SRA `0xF000_0000` by 4, STEP 2 → `0xFF00_0000` after 2 edges. SLL `0x0000_0001` by 0 → `0x0000_0001` after 1 edge.
- Backpressure: hold `i_ready` = 0 for 5 cycles in DONE → `o_result` stable, `o_ready` 0; on `i_ready` = 1, IDLE on the next edge.
- Change `i_data` and `i_op` during BUSY → result depends only on the accepted values.
- Assert `i_rst_n` = 0 mid-BUSY → next cycle `o_valid` 0, `o_result` 0, and `o_ready` 1 once reset is released. A following request completes correctly.
- With `ALU_SHIFT_ROTATE_EN`: ROR `0x0000_0001` by 1 → `0x8000_0000`. Without the macro, the same stimulus → `0x0000_0000`.
